// File: rtl/sram22_2048x32_ctrl.sv
// sram22_2048x32_ctrl: request/response front-end for a 2048x32 byte-masked
// single-port SRAM22 macro. Requests drive the macro pins combinationally on
// a fire. Read data returns one cycle later and is captured into a small
// circular response FIFO. A credit check on req_ready keeps the FIFO from
// ever overflowing.
module sram22_2048x32_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8,
  parameter int RSP_DEPTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_dout,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_DEPTH);

  logic                  fire_p0;
  logic                  rd_fire_p0;
  logic                  vld_p1;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count;
  logic [CW:0]           used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];

  // Circular pointer advance; RSP_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Stage p0: request handshake and macro pins.
  // Credits count both stored responses and the read whose data is still
  // on the macro's dout, so a push can always find a free slot.
  assign used       = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign req_ready  = !rst && (used < DEPTH_C);
  assign fire_p0    = req_valid && req_ready;
  assign rd_fire_p0 = fire_p0 && !req_we;

  // Non-fire cycles issue a write with an empty mask: touches no memory.
  assign sram_we    = fire_p0 ? req_we    : 1'b1;
  assign sram_wmask = fire_p0 ? req_wmask : '0;
  assign sram_addr  = fire_p0 ? req_addr  : '0;
  assign sram_din   = fire_p0 ? req_din   : '0;

  // Stage p1: macro dout holds read data; capture it into the FIFO.
  assign push      = vld_p1;
  assign rsp_valid = !rst && (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_dout  = rsp_mem[rd_ptr];

  // Control state: in-flight flag, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      assert ({1'b0, count} <= DEPTH_C);
      assert (!(push && !pop && ({1'b0, count} == DEPTH_C)));
      vld_p1 <= rd_fire_p0;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response storage; data path carries no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) rsp_mem[wr_ptr] <= sram_dout;
  end

endmodule

// File: tb/tb_sram22_2048x32_ctrl.sv
// Directed bench for sram22_2048x32_ctrl with a behavioural SRAM macro model.
module tb_sram22_2048x32_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [10:0] req_addr;
  logic [31:0] req_din;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dout;
  logic        sram_we;
  logic [3:0]  sram_wmask;
  logic [10:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] macro_mem [2048] = '{default: 32'h0};

  sram22_2048x32_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dout   (rsp_dout),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // Macro model: byte-masked write, one-cycle read, dout undefined after a write.
  always @(posedge clk) begin
    if (sram_we) begin
      for (int k = 0; k < 4; k++)
        if (sram_wmask[k]) macro_mem[sram_addr][8*k +: 8] <= sram_din[8*k +: 8];
      sram_dout <= 'x;
    end else begin
      sram_dout <= macro_mem[sram_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [10:0] a);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wmask = 4'h0;
    req_din   = 32'h0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_din   = d;
    req_wmask = m;
    #1;
    chk1("wr_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
  endtask

  // Single read on an empty FIFO with rsp_ready=1: data appears two cycles after the fire.
  task automatic rd(input logic [10:0] a, input logic [31:0] exp, input string tag);
    set_rd(a);
    #1;
    chk1("rd_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    #1;
    chk1("rd_lat_n1", rsp_valid, 1'b0);
    cyc();
    chk1("rd_lat_n2", rsp_valid, 1'b1);
    chk32(tag, rsp_dout, exp);
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with a read request held to show no access leaks out.
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_rd(11'd5);
    cyc(); cyc(); cyc();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_sram_we", sram_we, 1'b1);
    chk32("rst_sram_wmask", {28'h0, sram_wmask}, 32'h0);
    chk32("rst_sram_addr", {21'h0, sram_addr}, 32'h0);
    chk32("rst_sram_din", sram_din, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk1("ready_after_rst", req_ready, 1'b1);
    chk1("idle_sram_we", sram_we, 1'b1);

    // Write then read back address 5.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd5; req_din = 32'hDEADBEEF; req_wmask = 4'hF;
    #1;
    chk1("fire_sram_we", sram_we, 1'b1);
    chk32("fire_sram_addr", {21'h0, sram_addr}, 32'd5);
    chk32("fire_sram_din", sram_din, 32'hDEADBEEF);
    cyc();
    set_rd(11'd5);
    #1;
    chk1("rd_sram_we", sram_we, 1'b0);
    req_valid = 1'b0;
    rd(11'd5, 32'hDEADBEEF, "wr_rd_5");

    // Byte mask merge.
    wr(11'd7, 32'h11223344, 4'hF);
    wr(11'd7, 32'hAABBCCDD, 4'b0101);
    rd(11'd7, 32'h11BB33DD, "byte_mask");
    wr(11'd7, 32'h55555555, 4'h0);
    rd(11'd7, 32'h11BB33DD, "zero_mask_noop");

    // Full-rate stream.
    for (int i = 0; i < 16; i++) wr(11'(i), 32'(i * 3), 4'hF);
    for (int i = 0; i < 16; i++) begin
      set_rd(11'(i));
      #1;
      chk1("stream_ready", req_ready, 1'b1);
      if (i >= 2) begin
        chk1("stream_valid", rsp_valid, 1'b1);
        chk32("stream_data", rsp_dout, 32'((i - 2) * 3));
      end
      cyc();
    end
    req_valid = 1'b0;
    #1;
    chk1("stream_valid14", rsp_valid, 1'b1);
    chk32("stream_data14", rsp_dout, 32'd42);
    cyc();
    chk1("stream_valid15", rsp_valid, 1'b1);
    chk32("stream_data15", rsp_dout, 32'd45);
    cyc();
    chk1("stream_drained", rsp_valid, 1'b0);

    // Backpressure: three reads accepted, then blocked.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_rd(11'(i));
      #1;
      chk1("bp_accept", req_ready, 1'b1);
      cyc();
    end
    set_rd(11'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_block", req_ready, 1'b0);
      chk1("bp_valid", rsp_valid, 1'b1);
      chk32("bp_head", rsp_dout, 32'd3);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk1("bp_ready_lag", req_ready, 1'b0);
    chk32("bp_pop0", rsp_dout, 32'd3);
    cyc();
    chk1("bp_ready_back", req_ready, 1'b1);
    chk32("bp_pop1", rsp_dout, 32'd6);
    cyc();
    set_rd(11'd5);
    #1;
    chk1("bp_ready5", req_ready, 1'b1);
    chk32("bp_pop2", rsp_dout, 32'd9);
    cyc();
    req_valid = 1'b0;
    chk1("bp_valid4", rsp_valid, 1'b1);
    chk32("bp_pop3", rsp_dout, 32'd12);
    cyc();
    chk1("bp_valid5", rsp_valid, 1'b1);
    chk32("bp_pop4", rsp_dout, 32'd15);
    cyc();
    chk1("bp_drained", rsp_valid, 1'b0);

    // Write-read hazards.
    wr(11'd2047, 32'hFFFFFFFF, 4'hF);
    rd(11'd2047, 32'hFFFFFFFF, "raw_2047");
    set_rd(11'd0);
    #1;
    chk1("war_rd_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd0; req_din = 32'hCAFEF00D; req_wmask = 4'hF;
    #1;
    chk1("war_wr_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    chk1("war_valid", rsp_valid, 1'b1);
    chk32("war_old_data", rsp_dout, 32'h0);
    cyc();
    rd(11'd0, 32'hCAFEF00D, "war_new_data");

    // Reset with two queued responses and one read in flight.
    rsp_ready = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      set_rd(11'(i));
      #1;
      chk1("mrst_accept", req_ready, 1'b1);
      cyc();
    end
    set_rd(11'd13);
    rst = 1'b1;
    #1;
    chk1("mrst_req_ready", req_ready, 1'b0);
    chk1("mrst_rsp_valid", rsp_valid, 1'b0);
    chk1("mrst_sram_we", sram_we, 1'b1);
    chk32("mrst_sram_wmask", {28'h0, sram_wmask}, 32'h0);
    chk32("mrst_sram_addr", {21'h0, sram_addr}, 32'h0);
    cyc();
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("mrst_no_stale", rsp_valid, 1'b0);
      chk1("mrst_ready", req_ready, 1'b1);
      cyc();
    end
    rd(11'd2047, 32'hFFFFFFFF, "mrst_keep_2047");
    rd(11'd11, 32'd33, "mrst_keep_11");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
